// File: rtl/nor_gate_unit.sv
// Bitwise two-input NOR with a combinational result and a registered, valid-qualified copy.
// Optional toggle counter is built only when NOR_GATE_UNIT_TOGGLE_CNT_EN is defined.
module nor_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             y_all,
    output logic             y_none,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] y_next;
    logic             valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_nor_bit
            assign y[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    always_comb begin
        y_next = y_reg;
        if (in_valid) begin
            y_next = y;
        end
    end

    // Reset takes priority over a same-cycle in_valid, discarding that sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            y_reg     <= y_next;
            valid_reg <= in_valid;
        end
    end

    assign y_q       = y_reg;
    assign out_valid = valid_reg;
    assign y_all     = &y_reg;
    assign y_none    = ~|y_reg;

`ifdef NOR_GATE_UNIT_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count only accepted results that change y_q, saturating at all-ones.
    always_comb begin
        cnt_next = cnt_reg;
        if (in_valid && (y != y_reg) && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign toggle_cnt = cnt_reg;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_nor_gate_unit.sv
// Directed self-checking bench for nor_gate_unit: WIDTH=4 instance and a WIDTH=1, CNT_W=2 instance.
module tb_nor_gate_unit;

    logic       clk;
    logic       rst_n;

    logic [3:0] a4, b4;
    logic       v4;
    logic [3:0] y4, yq4;
    logic       ov4, all4, none4;
    logic [15:0] cnt4;

    logic       a1, b1;
    logic       v1;
    logic       y1, yq1;
    logic       ov1, all1, none1;
    logic [1:0] cnt1;

    int checks   = 0;
    int failures = 0;

    nor_gate_unit #(.WIDTH(4), .CNT_W(16)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
        .y(y4), .y_q(yq4), .out_valid(ov4), .y_all(all4), .y_none(none4),
        .toggle_cnt(cnt4)
    );

    nor_gate_unit #(.WIDTH(1), .CNT_W(2)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .y_all(all1), .y_none(none1),
        .toggle_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input string what);
        @(posedge clk);
        #1;
        $display("t=%0t %s: w4 a=%h b=%h v=%b -> y_q=%h ov=%b | w1 a=%b v=%b -> y_q=%b cnt=%0d",
                 $time, what, a4, b4, v4, yq4, ov4, a1, v1, yq1, cnt1);
    endtask

    logic [1:0] exp_cnt [5];

    initial begin
        rst_n = 1'b0;
        a4 = 4'h0; b4 = 4'h0; v4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;

        // Truth table on the combinational path (WIDTH=1)
        a1 = 0; b1 = 0; #1; check_value("tt_00", y1, 1);
        a1 = 1; b1 = 0; #1; check_value("tt_10", y1, 0);
        a1 = 0; b1 = 1; #1; check_value("tt_01", y1, 0);
        a1 = 1; b1 = 1; #1; check_value("tt_11", y1, 0);

        // a toggles every 2 units, b every 3
        for (int t = 0; t < 10; t++) begin
            a1 = ((t / 2) % 2) != 0;
            b1 = ((t / 3) % 2) != 0;
            #1;
            check_value($sformatf("track_t%0d", t), y1, ((t / 2) % 2 == 0 && (t / 3) % 2 == 0) ? 1 : 0);
        end

        // Reset for two edges with a=b=0, in_valid=1
        a1 = 0; b1 = 0; v1 = 1; a4 = 0; b4 = 0; v4 = 1; rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            tick("reset");
            check_value("rst_yq4", yq4, 0);
            check_value("rst_ov4", ov4, 0);
            check_value("rst_none4", none4, 1);
            check_value("rst_all4", all4, 0);
            check_value("rst_y4", y4, 4'hF);
            check_value("rst_yq1", yq1, 0);
            check_value("rst_ov1", ov1, 0);
            check_value("rst_none1", none1, 1);
            check_value("rst_y1", y1, 1);
            check_value("rst_cnt1", cnt1, 0);
        end

        // Capture then hold, WIDTH=4
        v1 = 0;
        rst_n = 1; a4 = 4'b0101; b4 = 4'b0011; v4 = 1;
        tick("capture");
        check_value("cap_yq", yq4, 4'b1000);
        check_value("cap_ov", ov4, 1);
        check_value("cap_all", all4, 0);
        check_value("cap_none", none4, 0);

        v4 = 0; a4 = 0; b4 = 0;
        #1; check_value("mid_yq", yq4, 4'b1000);
        tick("hold");
        check_value("hold_yq", yq4, 4'b1000);
        check_value("hold_ov", ov4, 0);
        check_value("hold_y", y4, 4'b1111);

        // Flags
        v4 = 1; a4 = 0; b4 = 0;
        tick("flags_ones");
        check_value("ones_yq", yq4, 4'hF);
        check_value("ones_all", all4, 1);
        check_value("ones_none", none4, 0);
        check_value("b2b_ov", ov4, 1);

        a4 = 4'hF;
        tick("flags_zero");
        check_value("zero_yq", yq4, 4'h0);
        check_value("zero_all", all4, 0);
        check_value("zero_none", none4, 1);
        check_value("b2b_ov2", ov4, 1);

        // Reset beats in_valid on the same edge
        a4 = 0;
        tick("preload");
        check_value("pre_yq", yq4, 4'hF);
        rst_n = 0; v4 = 1;
        tick("rst_prio");
        check_value("prio_yq", yq4, 0);
        check_value("prio_ov", ov4, 0);
        rst_n = 1; v4 = 0;

        // Toggle counter, WIDTH=1 CNT_W=2: y_q starts at 0
`ifdef NOR_GATE_UNIT_TOGGLE_CNT_EN
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        exp_cnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        v1 = 1; b1 = 0;
        for (int i = 0; i < 5; i++) begin
            a1 = (i % 2) != 0;
            tick("toggle");
            check_value($sformatf("tog_yq_%0d", i), yq1, (i % 2 == 0) ? 1 : 0);
            check_value($sformatf("tog_ov_%0d", i), ov1, 1);
            check_value($sformatf("tog_all_%0d", i), all1, (i % 2 == 0) ? 1 : 0);
            check_value($sformatf("tog_cnt_%0d", i), cnt1, exp_cnt[i]);
        end
        v1 = 0;
        tick("idle");
        check_value("idle_ov1", ov1, 0);
        check_value("cnt4_zero", cnt4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
